// File: rtl/glb_bank_responder_pkg.sv
// Shared types and constants for the GLB bank endpoint of the wr/rdrq/rdrs switch protocol.
package glb_bank_responder_pkg;

  localparam int unsigned BANK_DATA_WIDTH      = 64;
  localparam int unsigned BANK_ADDR_WIDTH      = 17;
  localparam int unsigned BANK_STRB_WIDTH      = BANK_DATA_WIDTH / 8;
  localparam int unsigned BANK_WORD_ADDR_WIDTH = BANK_ADDR_WIDTH - 3;
  localparam int unsigned GLB_BANK_RD_LATENCY  = 3;

  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [BANK_ADDR_WIDTH-1:0] wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

  typedef struct packed {
    logic                       rd_en;
    logic [BANK_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic                       rd_data_valid;
    logic [BANK_DATA_WIDTH-1:0] rd_data;
  } rdrs_packet_t;

  typedef struct packed {
    logic [BANK_WORD_ADDR_WIDTH-1:0] addr;
    logic [BANK_STRB_WIDTH-1:0]      strb;
    logic [BANK_DATA_WIDTH-1:0]      data;
  } wbuf_entry_t;

  function automatic logic [BANK_WORD_ADDR_WIDTH-1:0] word_addr(input logic [BANK_ADDR_WIDTH-1:0] addr);
    return addr[BANK_ADDR_WIDTH-1:3];
  endfunction

  function automatic logic [BANK_DATA_WIDTH-1:0] strb_to_mask(input logic [BANK_STRB_WIDTH-1:0] strb);
    logic [BANK_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int unsigned b = 0; b < BANK_STRB_WIDTH; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/glb_bank_responder_wbuf.sv
// Write buffer: shift FIFO (entry 0 oldest) with parallel address compare and per-byte forwarding merge.
module glb_bank_wbuf
  import glb_bank_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  wbuf_entry_t                     push_entry,
  input  logic                            pop,
  output logic                            empty,
  output logic                            full,
  output wbuf_entry_t                     head,
  input  logic [BANK_WORD_ADDR_WIDTH-1:0] lookup_addr,
  output logic [BANK_STRB_WIDTH-1:0]      fwd_strb,
  output logic [BANK_DATA_WIDTH-1:0]      fwd_data
);

  wbuf_entry_t      ent     [DEPTH];
  wbuf_entry_t      ent_nxt [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic             placed;

  assign empty = !vld[0];
  assign full  = vld[DEPTH-1];
  assign head  = ent[0];

  // Pop shifts everything toward the head; push lands in the first free slot after the shift.
  always_comb begin
    ent_nxt = ent;
    vld_nxt = vld;
    placed  = 1'b0;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        ent_nxt[i] = ent[i+1];
        vld_nxt[i] = vld[i+1];
      end
      ent_nxt[DEPTH-1] = '0;
      vld_nxt[DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!placed && !vld_nxt[i]) begin
          ent_nxt[i] = push_entry;
          vld_nxt[i] = 1'b1;
          placed     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent[i] <= '0;
      end
    end else begin
      vld <= vld_nxt;
      ent <= ent_nxt;
    end
  end

  // Walk oldest to youngest so the youngest matching write owns each byte.
  always_comb begin
    fwd_strb = '0;
    fwd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld[i] && (ent[i].addr == lookup_addr)) begin
        for (int unsigned b = 0; b < BANK_STRB_WIDTH; b++) begin
          if (ent[i].strb[b]) begin
            fwd_strb[b]        = 1'b1;
            fwd_data[b*8 +: 8] = ent[i].data[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/glb_bank_responder.sv
// GLB bank endpoint: drives one single-port SRAM from switch wr/rdrq packets, returns rdrs at fixed latency.
module glb_bank_responder
  import glb_bank_responder_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  wr_packet_t                      wr_packet,
  input  rdrq_packet_t                    rdrq_packet,
  output rdrs_packet_t                    rdrs_packet,
  output logic                            mem_cen,
  output logic                            mem_wen,
  output logic [BANK_WORD_ADDR_WIDTH-1:0] mem_addr,
  output logic [BANK_DATA_WIDTH-1:0]      mem_wdata,
  output logic [BANK_DATA_WIDTH-1:0]      mem_bwe,
  input  logic [BANK_DATA_WIDTH-1:0]      mem_rdata,
  output logic                            wbuf_ovf
);

  wr_packet_t                 s0_wr;
  rdrq_packet_t               s0_rd;
  logic                       rd_go;
  logic                       wr_direct;
  logic                       wr_enq;
  logic                       wb_push;
  logic                       wb_pop;
  logic                       wb_empty;
  logic                       wb_full;
  wbuf_entry_t                wb_head;
  wbuf_entry_t                s1_entry;
  logic [BANK_STRB_WIDTH-1:0] wb_fwd_strb;
  logic [BANK_DATA_WIDTH-1:0] wb_fwd_data;
  logic [BANK_STRB_WIDTH-1:0] s1_fwd_strb;
  logic [BANK_DATA_WIDTH-1:0] s1_fwd_data;
  logic                       s2_valid;
  logic [BANK_STRB_WIDTH-1:0] s2_fwd_strb;
  logic [BANK_DATA_WIDTH-1:0] s2_fwd_data;
  logic [BANK_DATA_WIDTH-1:0] s2_mask;
  logic [BANK_DATA_WIDTH-1:0] s2_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_wr <= '0;
      s0_rd <= '0;
    end else begin
      s0_wr <= wr_packet;
      s0_rd <= rdrq_packet;
    end
  end

  // S1 port arbitration: read, then oldest buffered write, then the fresh write if nothing is queued.
  always_comb begin
    rd_go          = s0_rd.rd_en;
    s1_entry.addr  = word_addr(s0_wr.wr_addr);
    s1_entry.strb  = s0_wr.wr_strb;
    s1_entry.data  = s0_wr.wr_data;
    wb_pop         = !rd_go && !wb_empty;
    wr_direct      = s0_wr.wr_en && !rd_go && wb_empty;
    wr_enq         = s0_wr.wr_en && !wr_direct;
    wb_push        = wr_enq && !wb_full;
    mem_cen        = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_bwe        = '0;
    if (rd_go) begin
      mem_cen  = 1'b1;
      mem_addr = word_addr(s0_rd.rd_addr);
    end else if (wb_pop) begin
      mem_cen   = 1'b1;
      mem_wen   = 1'b1;
      mem_addr  = wb_head.addr;
      mem_wdata = wb_head.data;
      mem_bwe   = strb_to_mask(wb_head.strb);
    end else if (wr_direct) begin
      mem_cen   = 1'b1;
      mem_wen   = 1'b1;
      mem_addr  = s1_entry.addr;
      mem_wdata = s1_entry.data;
      mem_bwe   = strb_to_mask(s1_entry.strb);
    end
  end

  glb_bank_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .push        (wb_push),
    .push_entry  (s1_entry),
    .pop         (wb_pop),
    .empty       (wb_empty),
    .full        (wb_full),
    .head        (wb_head),
    .lookup_addr (word_addr(s0_rd.rd_addr)),
    .fwd_strb    (wb_fwd_strb),
    .fwd_data    (wb_fwd_data)
  );

  // The write being enqueued this cycle is younger than every buffered entry, so it overlays last.
  always_comb begin
    s1_fwd_strb = wb_fwd_strb;
    s1_fwd_data = wb_fwd_data;
    if (wb_push && (s1_entry.addr == word_addr(s0_rd.rd_addr))) begin
      for (int unsigned b = 0; b < BANK_STRB_WIDTH; b++) begin
        if (s1_entry.strb[b]) begin
          s1_fwd_strb[b]        = 1'b1;
          s1_fwd_data[b*8 +: 8] = s1_entry.data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_fwd_strb <= '0;
      s2_fwd_data <= '0;
      wbuf_ovf    <= 1'b0;
    end else begin
      s2_valid    <= rd_go;
      s2_fwd_strb <= rd_go ? s1_fwd_strb : '0;
      s2_fwd_data <= rd_go ? s1_fwd_data : '0;
      wbuf_ovf    <= wbuf_ovf | (wr_enq && wb_full);
    end
  end

  assign s2_mask  = strb_to_mask(s2_fwd_strb);
  assign s2_rdata = (mem_rdata & ~s2_mask) | (s2_fwd_data & s2_mask);

  always_ff @(posedge clk) begin
    if (reset || !s2_valid) begin
      rdrs_packet <= '0;
    end else begin
      rdrs_packet.rd_data_valid <= 1'b1;
      rdrs_packet.rd_data       <= s2_rdata;
    end
  end

endmodule

// File: tb/tb_glb_bank_responder.sv
// Scoreboard bench for glb_bank_responder: directed vectors, then slotted random traffic against a byte model.
module tb_glb_bank_responder;
  import glb_bank_responder_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  wr_packet_t   wr_packet;
  rdrq_packet_t rdrq_packet;
  rdrs_packet_t rdrs_packet;
  logic         mem_cen;
  logic         mem_wen;
  logic [13:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_bwe;
  logic [63:0]  mem_rdata = '0;
  logic         wbuf_ovf;

  glb_bank_responder #(.WBUF_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_packet   (wr_packet),
    .rdrq_packet (rdrq_packet),
    .rdrs_packet (rdrs_packet),
    .mem_cen     (mem_cen),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_bwe     (mem_bwe),
    .mem_rdata   (mem_rdata),
    .wbuf_ovf    (wbuf_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int n_rd   = 0;
  bit mon_en = 1'b0;

  // Single-port SRAM with one-cycle read latency.
  logic [63:0] sram [logic [13:0]];
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen)
        sram[mem_addr] = ((sram.exists(mem_addr) ? sram[mem_addr] : 64'h0) & ~mem_bwe) | (mem_wdata & mem_bwe);
      else
        mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : 64'h0;
    end
  end

  logic [63:0] ref_mem [logic [13:0]];

  function automatic logic [63:0] ref_rd(input logic [16:0] addr);
    return ref_mem.exists(addr[16:3]) ? ref_mem[addr[16:3]] : 64'h0;
  endfunction

  task automatic ref_write(input logic [16:0] addr, input logic [7:0] strb, input logic [63:0] data);
    logic [63:0] w;
    w = ref_rd(addr);
    for (int b = 0; b < 8; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
    ref_mem[addr[16:3]] = w;
  endtask

  typedef struct {
    int          due;
    logic [63:0] data;
    int          id;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Drive one cycle of traffic; reads push their expected response (hand value or model value).
  task automatic issue(input logic we, input logic [7:0] strb, input logic [16:0] waddr, input logic [63:0] wdata,
                       input logic re, input logic [16:0] raddr, input logic [63:0] exp_data,
                       input bit wdrop, input bit use_model);
    exp_t e;
    wr_packet   = '{wr_en: we, wr_strb: strb, wr_addr: waddr, wr_data: wdata};
    rdrq_packet = '{rd_en: re, rd_addr: raddr};
    if (we && !wdrop) ref_write(waddr, strb, wdata);
    if (re) begin
      e.due  = cyc + int'(GLB_BANK_RD_LATENCY);
      e.data = use_model ? ref_rd(raddr) : exp_data;
      e.id   = n_rd++;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    wr_packet   = '0;
    rdrq_packet = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [16:0] addr, input logic [63:0] exp_data);
    issue(1'b0, 8'h00, 17'h0, 64'h0, 1'b1, addr, exp_data, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [16:0] addr, input logic [7:0] strb, input logic [63:0] data);
    issue(1'b1, strb, addr, data, 1'b0, 17'h0, 64'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every response must match the queue head on exactly its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missed_read id=%0d due=%0d now=%0d", exp_q[0].id, exp_q[0].due, cyc);
        mon_e = exp_q.pop_front();
      end
      if (rdrs_packet.rd_data_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got=%h cycle=%0d", rdrs_packet.rd_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.due != cyc || mon_e.data !== rdrs_packet.rd_data) begin
            errors++;
            $display("FAIL rd_data id=%0d got=%h@%0d want=%h@%0d", mon_e.id, rdrs_packet.rd_data, cyc, mon_e.data, mon_e.due);
          end
        end
      end else begin
        chk("idle_rdrs_zero", rdrs_packet.rd_data, 64'h0);
      end
    end
  end

  logic [16:0] bases [4] = '{17'h040, 17'h048, 17'h080, 17'h300};

  initial begin
    reset       = 1'b1;
    wr_packet   = '0;
    rdrq_packet = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdrs_valid", 64'(rdrs_packet.rd_data_valid), 64'h0);
    chk("rst_rdrs_data", rdrs_packet.rd_data, 64'h0);
    chk("rst_mem_cen", 64'(mem_cen), 64'h0);
    chk("rst_mem_wen", 64'(mem_wen), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_mem_bwe", mem_bwe, 64'h0);
    chk("rst_wbuf_ovf", 64'(wbuf_ovf), 64'h0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Plain write then read; zero-strobe write changes nothing; byte offset bits ignored.
    wr(17'h040, 8'hFF, 64'h1122334455667788);
    idle(3);
    rd(17'h040, 64'h1122334455667788);
    wr(17'h040, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(2);
    rd(17'h045, 64'h1122334455667788);
    idle(4);

    // Same-cycle write and read to different words: read owns the port, write drains next.
    issue(1'b1, 8'hFF, 17'h100, 64'hDEADBEEF_CAFEF00D, 1'b1, 17'h200, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_rd_cen", 64'(mem_cen), 64'h1);
    chk("t2_rd_wen", 64'(mem_wen), 64'h0);
    chk("t2_rd_addr", 64'(mem_addr), 64'h40);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_wr_cen", 64'(mem_cen), 64'h1);
    chk("t2_wr_wen", 64'(mem_wen), 64'h1);
    chk("t2_wr_addr", 64'(mem_addr), 64'h20);
    chk("t2_wr_data", mem_wdata, 64'hDEADBEEF_CAFEF00D);
    chk("t2_wr_bwe", mem_bwe, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    idle(2);
    rd(17'h100, 64'hDEADBEEF_CAFEF00D);
    idle(4);

    // Partial write held in the buffer by back-to-back reads is forwarded byte-wise.
    wr(17'h080, 8'hFF, 64'h0123456789ABCDEF);
    idle(2);
    rd(17'h080, 64'h0123456789ABCDEF);
    issue(1'b1, 8'h0F, 17'h080, 64'h0000_0000_AAAA_AAAA, 1'b1, 17'h080, 64'h01234567AAAAAAAA, 1'b0, 1'b0);
    repeat (5) rd(17'h080, 64'h01234567AAAAAAAA);
    idle(3);
    rd(17'h080, 64'h01234567AAAAAAAA);
    idle(4);

    // Overflow: third queued write is dropped and never becomes visible.
    @(negedge clk);
    chk("t4_ovf_before", 64'(wbuf_ovf), 64'h0);
    @(posedge clk); #1;
    issue(1'b1, 8'h01, 17'h300, 64'h11, 1'b1, 17'h300, 64'h11, 1'b0, 1'b0);
    issue(1'b1, 8'h02, 17'h300, 64'h2200, 1'b1, 17'h300, 64'h2211, 1'b0, 1'b0);
    issue(1'b1, 8'h04, 17'h300, 64'h330000, 1'b1, 17'h300, 64'h2211, 1'b1, 1'b0);
    repeat (3) rd(17'h300, 64'h2211);
    @(negedge clk);
    chk("t4_ovf_set", 64'(wbuf_ovf), 64'h1);
    @(posedge clk); #1;
    idle(3);
    rd(17'h300, 64'h2211);
    idle(4);
    @(negedge clk);
    chk("t4_ovf_sticky", 64'(wbuf_ovf), 64'h1);
    @(posedge clk); #1;

    // Reset one cycle after a read: read flushed, buffered write discarded, all outputs cleared.
    wr_packet   = '{wr_en: 1'b1, wr_strb: 8'hFF, wr_addr: 17'h048, wr_data: 64'h5555_5555_5555_5555};
    rdrq_packet = '{rd_en: 1'b1, rd_addr: 17'h040};
    @(posedge clk); #1;
    wr_packet   = '0;
    rdrq_packet = '0;
    reset       = 1'b1;
    idle(2);
    @(negedge clk);
    chk("t5_rdrs_valid", 64'(rdrs_packet.rd_data_valid), 64'h0);
    chk("t5_mem_cen", 64'(mem_cen), 64'h0);
    chk("t5_mem_wen", 64'(mem_wen), 64'h0);
    chk("t5_mem_addr", 64'(mem_addr), 64'h0);
    chk("t5_mem_bwe", mem_bwe, 64'h0);
    chk("t5_wbuf_ovf", 64'(wbuf_ovf), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    rd(17'h048, 64'h0);
    rd(17'h040, 64'h1122334455667788);
    idle(4);

    // Random slots: two traffic cycles then two quiet cycles so the buffer never overflows.
    for (int s = 0; s < 40; s++) begin
      for (int k = 0; k < 2; k++) begin
        issue(1'($urandom_range(0, 1)), 8'($urandom),
              17'(bases[$urandom_range(0, 3)] + 17'($urandom_range(0, 7))), {$urandom, $urandom},
              1'($urandom_range(0, 1)),
              17'(bases[$urandom_range(0, 3)] + 17'($urandom_range(0, 7))), 64'h0, 1'b0, 1'b1);
      end
      idle(2);
    end

    idle(6);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
